// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage MIPS pipeline.
// Handles continuous run, single-step and halt-drain sequencing, and a
// sticky watchdog for excessively long hazard stalls.
module pipeline_ctrl #(
   parameter int unsigned N_DRAIN      = 4,
   parameter int unsigned NB_DRAIN_CNT = 3,
   parameter int unsigned MAX_STALL    = 2,
   parameter int unsigned NB_STALL_CNT = 2,
   parameter bit          DELAY_SLOT   = 1'b1
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_valid,
   input  logic       i_mode,
   input  logic       i_step,
   input  logic       i_resume,
   input  logic       i_hazard,
   input  logic       i_branch_taken,
   input  logic       i_halt_id,
   output logic       o_pc_we,
   output logic       o_ifid_we,
   output logic       o_ifid_flush,
   output logic       o_idex_bubble,
   output logic       o_pipe_en,
   output logic       o_halted,
   output logic       o_stall_err,
   output logic [2:0] o_state
);

   localparam logic [2:0] RUN       = 3'd0;
   localparam logic [2:0] STEP_WAIT = 3'd1;
   localparam logic [2:0] STEP_GO   = 3'd2;
   localparam logic [2:0] DRAIN     = 3'd3;
   localparam logic [2:0] HALTED    = 3'd4;

   localparam logic [NB_DRAIN_CNT-1:0] DRAIN_LOAD = NB_DRAIN_CNT'(N_DRAIN - 1);
   localparam logic [NB_STALL_CNT-1:0] STALL_MAX  = NB_STALL_CNT'(MAX_STALL);

   logic [2:0]              state_q, state_d;
   logic [NB_DRAIN_CNT-1:0] drain_cnt_q, drain_cnt_d;
   logic [NB_STALL_CNT-1:0] stall_cnt_q, stall_cnt_d;
   logic                    stall_err_q, stall_err_d;

   logic pc_we, ifid_we, ifid_flush, idex_bubble, pipe_en;

   // Next-state and control decode; i_valid=0 leaves every *_d at its *_q
   always_comb begin
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      stall_cnt_d = stall_cnt_q;
      stall_err_d = stall_err_q;
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      pipe_en     = 1'b0;
      if (i_valid) begin
         case (state_q)
            RUN, STEP_GO: begin
               pipe_en = 1'b1;
               if (i_hazard) begin
                  // ID is not final during a stall: branch and halt wait
                  idex_bubble = 1'b1;
                  if (stall_cnt_q == STALL_MAX) begin
                     stall_err_d = 1'b1;
                  end else begin
                     stall_cnt_d = stall_cnt_q + 1'b1;
                  end
               end else begin
                  stall_cnt_d = '0;
                  if (i_halt_id) begin
                     ifid_flush  = 1'b1;
                     idex_bubble = 1'b1;
                  end else begin
                     pc_we      = 1'b1;
                     ifid_we    = 1'b1;
                     ifid_flush = i_branch_taken & ~DELAY_SLOT;
                  end
               end
               if (!i_hazard && i_halt_id) begin
                  state_d     = DRAIN;
                  drain_cnt_d = DRAIN_LOAD;
               end else if (state_q == STEP_GO || i_mode) begin
                  state_d = STEP_WAIT;
               end
            end
            STEP_WAIT: begin
               if (!i_mode) begin
                  state_d = RUN;
               end else if (i_step) begin
                  state_d = STEP_GO;
               end
            end
            DRAIN: begin
               idex_bubble = 1'b1;
               pipe_en     = 1'b1;
               // Counter is loaded with N_DRAIN-1 and leaves when it reaches 0,
               // so DRAIN lasts N_DRAIN-1 cycles after the halt cycle
               if (drain_cnt_q <= NB_DRAIN_CNT'(1)) begin
                  drain_cnt_d = '0;
                  state_d     = HALTED;
               end else begin
                  drain_cnt_d = drain_cnt_q - 1'b1;
               end
            end
            HALTED: begin
               if (i_resume) begin
                  state_d = i_mode ? STEP_WAIT : RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   // State registers with synchronous active-high reset
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q     <= RUN;
         drain_cnt_q <= '0;
         stall_cnt_q <= '0;
         stall_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         stall_err_q <= stall_err_d;
      end
   end

   // Outputs are masked while reset is asserted
   always_comb begin
      o_pc_we       = pc_we & ~i_reset;
      o_ifid_we     = ifid_we & ~i_reset;
      o_ifid_flush  = ifid_flush & ~i_reset;
      o_idex_bubble = idex_bubble & ~i_reset;
      o_pipe_en     = pipe_en & ~i_reset;
      o_halted      = (state_q == HALTED) & ~i_reset;
      o_stall_err   = stall_err_q & ~i_reset;
      o_state       = state_q;
   end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central sequencer for the 5-stage MIPS pipeline.
- Consumes the hazard-detect output, branch/jump resolution and halt decode from ID, plus debug-unit run/step commands.
- Drives PC write, IF/ID write and flush, ID/EX bubble insertion, and the advance enable of the EX/MEM/WB registers.
- Implements continuous, single-step and halt-drain sequencing.

Parameters:
- N_DRAIN, 4, cycles after halt decode needed to retire EX/MEM/WB contents before HALTED.
- NB_DRAIN_CNT, 3, width of the drain counter; must hold N_DRAIN-1.
- MAX_STALL, 2, consecutive hazard-stall cycles allowed before o_stall_err is raised.
- NB_STALL_CNT, 2, width of the stall counter; must hold MAX_STALL.
- DELAY_SLOT, 1, 1 = branch delay slot (no IF/ID flush on taken branch); 0 = flush IF/ID on taken branch.

Ports:
- i_clock  in  1  system clock, all state on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  global enable from debug unit; 0 freezes all state and forces every enable output to 0.
- i_mode  in  1  0 = continuous run, 1 = single-step.
- i_step  in  1  one-cycle pulse: advance the pipeline one cycle (step mode only).
- i_resume  in  1  leave HALTED.
- i_hazard  in  1  stall request from hazard unit (load-use, branch operand not ready).
- i_branch_taken  in  1  jump/branch in ID resolved taken.
- i_halt_id  in  1  halt opcode decoded in ID.
- o_pc_we  out  1  PC register write enable.
- o_ifid_we  out  1  IF/ID register write enable.
- o_ifid_flush  out  1  clear IF/ID to NOP.
- o_idex_bubble  out  1  load NOP into ID/EX instead of decoded instruction.
- o_pipe_en  out  1  advance enable for ID/EX, EX/MEM, MEM/WB.
- o_halted  out  1  state == HALTED.
- o_stall_err  out  1  sticky watchdog error.
- o_state  out  3  current state code.

Behaviour:
- State codes: RUN=0, STEP_WAIT=1, STEP_GO=2, DRAIN=3, HALTED=4.
- Registers: state, drain_cnt, stall_cnt, stall_err. Control outputs are combinational from state and inputs so a stall takes effect in the same cycle.
- Reset (i_reset=1 at edge): state=RUN, drain_cnt=0, stall_cnt=0, stall_err=0. While i_reset=1, all enable/flush/bubble outputs are 0, o_halted=0, o_stall_err=0.
- i_valid=0: pc_we, ifid_we, ifid_flush, idex_bubble and pipe_en are 0. No register changes. o_halted, o_state and o_stall_err reflect the held state.
- Advance cycle: state is RUN or STEP_GO with i_valid=1. Priority, highest first:
  1. i_hazard: pc_we=0, ifid_we=0, idex_bubble=1, pipe_en=1, ifid_flush=0. Branch and halt are ignored this cycle because ID is not final.
  2. i_halt_id: pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, pipe_en=1. Next state DRAIN, drain_cnt loaded with N_DRAIN-1.
  3. i_branch_taken: pc_we=1, ifid_we=1, pipe_en=1, ifid_flush=~DELAY_SLOT.
  4. Otherwise: pc_we=1, ifid_we=1, pipe_en=1, flush=0, bubble=0.
- Stall watchdog:
  - Advance cycle with i_hazard: stall_cnt increments, saturating at MAX_STALL.
  - Advance cycle without i_hazard: stall_cnt=0.
  - stall_err is set when stall_cnt==MAX_STALL and i_hazard=1 on an advance cycle, i.e. the (MAX_STALL+1)th consecutive stall. It is sticky until reset.
  - The stall itself is still honoured.
- RUN transitions:
  - Halt goes to DRAIN (priority over mode).
  - Else i_mode=1 goes to STEP_WAIT; the current cycle still advances.
- STEP_WAIT: all enables 0. i_mode=0 goes to RUN (wins over a simultaneous i_step). Else i_step=1 goes to STEP_GO.
- STEP_GO: exactly one advance cycle. Next state is DRAIN if halt was taken, else STEP_WAIT. i_step is ignored here.
- DRAIN:
  - Outputs: pc_we=0, ifid_we=0, ifid_flush=0, idex_bubble=1, pipe_en=1.
  - i_hazard, i_step and i_mode are ignored.
  - drain_cnt decrements each valid cycle; when drain_cnt==0, next state is HALTED.
  - Total DRAIN duration is N_DRAIN-1 cycles after the halt cycle.
- HALTED: all enables 0, o_halted=1. i_resume goes to RUN if i_mode=0, else STEP_WAIT. PC is untouched; fetch restarts at the held PC.
- Reset mid-DRAIN or mid-step returns to RUN next cycle; drain is abandoned.

Test Plan:
- Load-use: RUN, i_hazard=1 for one cycle → that cycle pc_we=0, ifid_we=0, idex_bubble=1, pipe_en=1; next cycle pc_we=1; stall_err=0.
- Hazard+branch same cycle, then branch alone: cycle 1 stall (pc_we=0, flush=0); cycle 2 pc_we=1, ifid_flush=0 with DELAY_SLOT=1, and ifid_flush=1 when rerun with DELAY_SLOT=0.
- Watchdog (MAX_STALL=2): i_hazard high 3 consecutive cycles → o_stall_err rises after 3rd cycle edge and stays 1 after hazard drops until i_reset.
- Halt (N_DRAIN=4): i_halt_id in RUN → flush=1 and bubble=1 that cycle; o_state=3 for 3 cycles with pc_we=0, pipe_en=1; then o_state=4, o_halted=1, all enables 0. i_resume with i_mode=0 → RUN, pc_we=1.
- Single-step: i_mode=1 → STEP_WAIT with enables 0 for 10 idle cycles. One i_step pulse → exactly one cycle with pc_we=1, pipe_en=1, then back to STEP_WAIT. i_step and i_mode=0 together → RUN.
- Freeze/reset: i_valid=0 during DRAIN for 5 cycles → o_state and drain_cnt unchanged, enables 0. i_reset=1 mid-DRAIN → next cycle o_state=0, o_halted=0, o_stall_err=0.
